data_memory_arbiter: RTL

//  Shares the single-port data memory (7-bit word address, 127 words) between two requesters:

---
 rtl/data_memory_arbiter.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter
// Shares one single-port data memory between two requesters:
//   port 0 = core load/store unit, port 1 = debug/DMA loader.
// Round-robin valid/ready arbitration with a two-state sequencer (IDLE/ACCESS).
// Each accepted request is driven onto the memory strobes for exactly one
// ACCESS cycle. The response pulses on the winning port in the IDLE cycle
// that follows. A new request may be accepted in that same cycle, so one
// access completes every two cycles.
// The memory writes on posedge clk and latches read data on negedge clk, so a
// load's data is stable by the posedge that ends ACCESS.
// Optional feature: define DATA_MEMORY_ARB_PERF_EN to add 16-bit saturating
// grant/conflict counters and their output ports.

module data_memory_arbiter #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 127
) (
  input  logic                  clk,
  input  logic                  reset,
  // port 0: core load/store unit
  input  logic                  req0_valid,
  input  logic                  req0_write,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  req0_ready,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_rdata,
  output logic                  rsp0_err,
  // port 1: debug/DMA loader
  input  logic                  req1_valid,
  input  logic                  req1_write,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  req1_ready,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,
  output logic                  rsp1_err,
  // data memory interface
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic [DATA_WIDTH-1:0] mem_read_data
`ifdef DATA_MEMORY_ARB_PERF_EN
  ,
  output logic [15:0]           perf_grant0,
  output logic [15:0]           perf_grant1,
  output logic [15:0]           perf_conflict
`endif
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = (ADDR_WIDTH + 1)'(MEM_DEPTH);

  state_t                  state_q;
  logic                    rr_ptr_q;       // port favoured when both are valid
  logic                    cap_port_q;     // winner of the access in flight
  logic                    cap_write_q;
  logic                    cap_inrange_q;

  logic                    mem_read_q;
  logic                    mem_write_q;
  logic [ADDR_WIDTH-1:0]   mem_address_q;
  logic [DATA_WIDTH-1:0]   mem_write_data_q;

  logic [1:0]              rsp_valid_q;
  logic [1:0]              rsp_err_q;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q [2];

  // Per-port views of the request bundles so that selection is indexed.
  logic [1:0]              req_valid;
  logic [1:0]              req_write;
  logic [ADDR_WIDTH-1:0]   req_addr  [2];
  logic [DATA_WIDTH-1:0]   req_wdata [2];

  // Combinational grant and the selected request fields.
  logic [1:0]              grant_d;
  logic                    win_port_d;
  logic                    sel_write_d;
  logic [ADDR_WIDTH-1:0]   sel_addr_d;
  logic [DATA_WIDTH-1:0]   sel_wdata_d;
  logic                    sel_inrange_d;

  assign req_valid    = {req1_valid, req0_valid};
  assign req_write    = {req1_write, req0_write};
  assign req_addr[0]  = req0_addr;
  assign req_addr[1]  = req1_addr;
  assign req_wdata[0] = req0_wdata;
  assign req_wdata[1] = req1_wdata;

  // Round-robin winner selection; only possible while IDLE.
  always_comb begin
    grant_d = 2'b00;
    if (state_q == ST_IDLE) begin
      if (req_valid[0] && (!req_valid[1] || !rr_ptr_q)) begin
        grant_d[0] = 1'b1;
      end else if (req_valid[1]) begin
        grant_d[1] = 1'b1;
      end
    end
  end

  // Mux the winning request's fields and classify its address.
  always_comb begin
    win_port_d    = grant_d[1];
    sel_write_d   = req_write[win_port_d];
    sel_addr_d    = req_addr[win_port_d];
    sel_wdata_d   = req_wdata[win_port_d];
    sel_inrange_d = ({1'b0, sel_addr_d} < DEPTH_LIMIT);
  end

  // Sequencer: capture on accept, strobe memory in ACCESS, respond after.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      rr_ptr_q         <= 1'b0;
      cap_port_q       <= 1'b0;
      cap_write_q      <= 1'b0;
      cap_inrange_q    <= 1'b0;
      mem_read_q       <= 1'b0;
      mem_write_q      <= 1'b0;
      mem_address_q    <= '0;
      mem_write_data_q <= '0;
      rsp_valid_q      <= 2'b00;
      rsp_err_q        <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        rsp_rdata_q[i] <= '0;
      end
    end else begin
      // Responses are single-cycle pulses.
      rsp_valid_q <= 2'b00;
      rsp_err_q   <= 2'b00;
      case (state_q)
        ST_IDLE: begin
          if (grant_d != 2'b00) begin
            state_q          <= ST_ACCESS;
            rr_ptr_q         <= ~win_port_d;
            cap_port_q       <= win_port_d;
            cap_write_q      <= sel_write_d;
            cap_inrange_q    <= sel_inrange_d;
            mem_address_q    <= sel_addr_d;
            mem_write_data_q <= sel_wdata_d;
            // Out-of-range requests never touch the memory.
            mem_write_q      <= sel_write_d & sel_inrange_d;
            mem_read_q       <= ~sel_write_d & sel_inrange_d;
          end
        end
        ST_ACCESS: begin
          state_q                 <= ST_IDLE;
          mem_read_q              <= 1'b0;
          mem_write_q             <= 1'b0;
          rsp_valid_q[cap_port_q] <= 1'b1;
          rsp_err_q[cap_port_q]   <= ~cap_inrange_q;
          // Load data was latched by the memory at the mid-ACCESS negedge.
          if (!cap_write_q) begin
            rsp_rdata_q[cap_port_q] <= cap_inrange_q ? mem_read_data : '0;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b0;
        end
      endcase
    end
  end

  assign req0_ready     = grant_d[0];
  assign req1_ready     = grant_d[1];
  assign rsp0_valid     = rsp_valid_q[0];
  assign rsp1_valid     = rsp_valid_q[1];
  assign rsp0_err       = rsp_err_q[0];
  assign rsp1_err       = rsp_err_q[1];
  assign rsp0_rdata     = rsp_rdata_q[0];
  assign rsp1_rdata     = rsp_rdata_q[1];
  assign mem_read       = mem_read_q;
  assign mem_write      = mem_write_q;
  assign mem_address    = mem_address_q;
  assign mem_write_data = mem_write_data_q;

`ifdef DATA_MEMORY_ARB_PERF_EN
  logic [15:0] perf_grant_q [2];
  logic [15:0] perf_conflict_q;
  logic        conflict_d;

  assign conflict_d = (state_q == ST_IDLE) && req_valid[0] && req_valid[1];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_perf_grant
      // Saturating count of accepts on port gi.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          perf_grant_q[gi] <= '0;
        end else if (grant_d[gi] && (perf_grant_q[gi] != 16'hFFFF)) begin
          perf_grant_q[gi] <= perf_grant_q[gi] + 16'd1;
        end
      end
    end
  endgenerate

  // Saturating count of IDLE cycles in which both ports contend.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_conflict_q <= '0;
    end else if (conflict_d && (perf_conflict_q != 16'hFFFF)) begin
      perf_conflict_q <= perf_conflict_q + 16'd1;
    end
  end

  assign perf_grant0   = perf_grant_q[0];
  assign perf_grant1   = perf_grant_q[1];
  assign perf_conflict = perf_conflict_q;
`endif

endmodule
